// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO arbiter and its poll timer.
package mdio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } mdio_arb_state_t;

  typedef enum logic {
    OWNER_HOST,
    OWNER_POLL
  } mdio_owner_t;

  localparam logic [4:0] MDIO_REG_BMSR = 5'd1;
  localparam int         BMSR_LINK_BIT = 2;

endpackage

// File: rtl/mdio_poll_timer.sv
// Poll interval down-counter; raises poll_pending on terminal count and
// flags an overrun when the previous round has not finished yet.
module mdio_poll_timer #(
  parameter int POLL_INTERVAL = 187500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic poll_en,
  input  logic round_clear,
  output logic poll_pending,
  output logic poll_overrun
);

  localparam int            CW     = $clog2(POLL_INTERVAL);
  localparam logic [CW-1:0] RELOAD = CW'(POLL_INTERVAL - 1);

  logic [CW-1:0] cnt;
  logic          expire;

  assign expire = poll_en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= RELOAD;
      poll_pending <= 1'b0;
      poll_overrun <= 1'b0;
    end else begin
      // A round finishing on the expiry cycle is not an overrun: the new round starts cleanly.
      poll_overrun <= expire && poll_pending && !round_clear;
      if (poll_en) begin
        cnt <= expire ? RELOAD : cnt - 1'b1;
      end
      if (expire) begin
        poll_pending <= 1'b1;
      end else if (round_clear) begin
        poll_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO transceiver between host register accesses and a
// periodic link-status poller, alternating ownership under contention.
//
// state      | meaning
// IDLE       | wait for a requester and an idle transceiver, pick owner
// ISSUE      | one-cycle rd/wr strobe to the transceiver
// WAIT_START | transceiver busy not yet valid, ignored
// WAIT_DONE  | wait for busy low, capture read data, retire transaction
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int                      NUM_PHYS      = 2,
  parameter logic [5*NUM_PHYS-1:0]   PHY_ADDRS     = {5'd1, 5'd0},
  parameter logic [4:0]              POLL_REG      = MDIO_REG_BMSR,
  parameter int                      LINK_BIT      = BMSR_LINK_BIT,
  parameter int                      POLL_INTERVAL = 187500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     poll_en,
  input  logic                     host_rd,
  input  logic                     host_wr,
  input  logic [4:0]               host_md_addr,
  input  logic [4:0]               host_reg_addr,
  input  logic [15:0]              host_wr_data,
  output logic                     host_busy,
  output logic                     host_done,
  output logic [15:0]              host_rd_data,
  output logic [NUM_PHYS-1:0]      link_up,
  output logic [16*NUM_PHYS-1:0]   poll_data,
  output logic                     poll_round_done,
  output logic                     poll_overrun,
  input  logic                     txvr_busy,
  input  logic [15:0]              txvr_rd_data,
  output logic [4:0]               txvr_md_addr,
  output logic [4:0]               txvr_reg_addr,
  output logic [15:0]              txvr_wr_data,
  output logic                     txvr_reg_rd,
  output logic                     txvr_reg_wr
);

  localparam int                IDX_W    = (NUM_PHYS > 1) ? $clog2(NUM_PHYS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_PHYS - 1);

  mdio_arb_state_t   state;
  mdio_owner_t       owner;
  mdio_owner_t       last_owner;
  logic [IDX_W-1:0]  idx;
  logic              host_is_wr;
  logic [4:0]        host_md;
  logic [4:0]        host_rg;
  logic [15:0]       host_wd;
  logic              poll_pending;
  logic              round_clear;
  logic              accept;
  logic              host_wins;
  logic [4:0]        poll_addr;

  assign accept      = !host_busy && (host_rd || host_wr);
  assign round_clear = (state == WAIT_DONE) && !txvr_busy &&
                       (owner == OWNER_POLL) && (idx == IDX_LAST);
  // Under contention the side that did not own the last transaction goes next.
  assign host_wins   = host_busy && (!poll_pending || last_owner == OWNER_POLL);
  assign poll_addr   = PHY_ADDRS[5*int'(idx) +: 5];

  mdio_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .poll_en     (poll_en),
    .round_clear (round_clear),
    .poll_pending(poll_pending),
    .poll_overrun(poll_overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner           <= OWNER_HOST;
      last_owner      <= OWNER_POLL;
      idx             <= '0;
      host_is_wr      <= 1'b0;
      host_md         <= '0;
      host_rg         <= '0;
      host_wd         <= '0;
      host_busy       <= 1'b0;
      host_done       <= 1'b0;
      host_rd_data    <= '0;
      link_up         <= '0;
      poll_data       <= '0;
      poll_round_done <= 1'b0;
      txvr_md_addr    <= '0;
      txvr_reg_addr   <= '0;
      txvr_wr_data    <= '0;
      txvr_reg_rd     <= 1'b0;
      txvr_reg_wr     <= 1'b0;
    end else begin
      host_done       <= 1'b0;
      poll_round_done <= 1'b0;
      txvr_reg_rd     <= 1'b0;
      txvr_reg_wr     <= 1'b0;

      if (accept) begin
        host_busy  <= 1'b1;
        host_is_wr <= host_wr;
        host_md    <= host_md_addr;
        host_rg    <= host_reg_addr;
        host_wd    <= host_wr_data;
      end

      case (state)
        IDLE: begin
          // Also covers a frame left running across a reset.
          if (!txvr_busy && (host_busy || poll_pending)) begin
            if (host_wins) begin
              owner         <= OWNER_HOST;
              txvr_md_addr  <= host_md;
              txvr_reg_addr <= host_rg;
              txvr_wr_data  <= host_wd;
              txvr_reg_wr   <= host_is_wr;
              txvr_reg_rd   <= !host_is_wr;
            end else begin
              owner         <= OWNER_POLL;
              txvr_md_addr  <= poll_addr;
              txvr_reg_addr <= POLL_REG;
              txvr_reg_rd   <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE:      state <= WAIT_START;
        WAIT_START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!txvr_busy) begin
            last_owner <= owner;
            state      <= IDLE;
            if (owner == OWNER_HOST) begin
              if (!host_is_wr) begin
                host_rd_data <= txvr_rd_data;
              end
              host_done <= 1'b1;
              host_busy <= 1'b0;
            end else begin
              poll_data[16*int'(idx) +: 16] <= txvr_rd_data;
              link_up[idx]                  <= txvr_rd_data[LINK_BIT];
              if (idx == IDX_LAST) begin
                poll_round_done <= 1'b1;
                idx             <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: a transceiver model answers frames and
// a scoreboard queue holds the transactions expected at the transceiver port.
module tb_mdio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        poll_en;
  logic        host_rd;
  logic        host_wr;
  logic [4:0]  host_md_addr;
  logic [4:0]  host_reg_addr;
  logic [15:0] host_wr_data;
  logic        host_busy;
  logic        host_done;
  logic [15:0] host_rd_data;
  logic [1:0]  link_up;
  logic [31:0] poll_data;
  logic        poll_round_done;
  logic        poll_overrun;
  logic        txvr_busy;
  logic [15:0] txvr_rd_data;
  logic [4:0]  txvr_md_addr;
  logic [4:0]  txvr_reg_addr;
  logic [15:0] txvr_wr_data;
  logic        txvr_reg_rd;
  logic        txvr_reg_wr;

  mdio_arbiter #(
    .NUM_PHYS     (2),
    .PHY_ADDRS    ({5'd1, 5'd0}),
    .POLL_REG     (5'd1),
    .LINK_BIT     (2),
    .POLL_INTERVAL(100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .poll_en        (poll_en),
    .host_rd        (host_rd),
    .host_wr        (host_wr),
    .host_md_addr   (host_md_addr),
    .host_reg_addr  (host_reg_addr),
    .host_wr_data   (host_wr_data),
    .host_busy      (host_busy),
    .host_done      (host_done),
    .host_rd_data   (host_rd_data),
    .link_up        (link_up),
    .poll_data      (poll_data),
    .poll_round_done(poll_round_done),
    .poll_overrun   (poll_overrun),
    .txvr_busy      (txvr_busy),
    .txvr_rd_data   (txvr_rd_data),
    .txvr_md_addr   (txvr_md_addr),
    .txvr_reg_addr  (txvr_reg_addr),
    .txvr_wr_data   (txvr_wr_data),
    .txvr_reg_rd    (txvr_reg_rd),
    .txvr_reg_wr    (txvr_reg_wr)
  );

  typedef struct packed {
    logic        wr;
    logic [4:0]  md;
    logic [4:0]  rg;
    logic [15:0] wd;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          issues = 0;
  int          busy_len = 10;
  logic [15:0] rsp_tab [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic txn_t mk(input logic wr, input logic [4:0] md, input logic [4:0] rg,
                              input logic [15:0] wd);
    txn_t t;
    t.wr = wr; t.md = md; t.rg = rg; t.wd = wd;
    return t;
  endfunction

  // Transceiver: busy rises two cycles after the strobe, lasts busy_len cycles.
  initial begin
    logic [4:0] a;
    txvr_busy    = 1'b0;
    txvr_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n && (txvr_reg_rd || txvr_reg_wr)) begin
        a = txvr_md_addr;
        @(posedge clk);
        @(posedge clk);
        #1 txvr_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 txvr_rd_data = rsp_tab[a];
        txvr_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every strobe must match the next expected transaction.
  always @(negedge clk) begin
    if (rst_n && (txvr_reg_rd || txvr_reg_wr)) begin
      issues++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got wr=%0b rd=%0b md=%0d reg=%0d, required no transaction",
                 txvr_reg_wr, txvr_reg_rd, txvr_md_addr, txvr_reg_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (txvr_reg_wr !== mon_e.wr || txvr_reg_rd !== !mon_e.wr || txvr_md_addr !== mon_e.md ||
            txvr_reg_addr !== mon_e.rg || (mon_e.wr && txvr_wr_data !== mon_e.wd)) begin
          errors++;
          $display("FAIL issue_fields: got wr=%0b rd=%0b md=%0d reg=%0d wd=%h, required wr=%0b md=%0d reg=%0d wd=%h",
                   txvr_reg_wr, txvr_reg_rd, txvr_md_addr, txvr_reg_addr, txvr_wr_data,
                   mon_e.wr, mon_e.md, mon_e.rg, mon_e.wd);
        end
      end
      checks++;
      if (txvr_busy !== 1'b0) begin
        errors++;
        $display("FAIL issue_while_busy: txvr_busy=%0b at issue, required 0", txvr_busy);
      end
    end
  end

  task automatic do_reset();
    poll_en = 1'b0; host_rd = 1'b0; host_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; poll_en = 1'b0; host_rd = 1'b0; host_wr = 1'b0;
    host_md_addr = '0; host_reg_addr = '0; host_wr_data = '0;
    for (int i = 0; i < 32; i++) rsp_tab[i] = 16'h0;
    @(negedge clk);
    checks++;
    if ({host_busy, host_done, poll_round_done, poll_overrun, txvr_reg_rd, txvr_reg_wr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {host_busy, host_done, poll_round_done, poll_overrun, txvr_reg_rd, txvr_reg_wr});
    end
    checks++;
    if (host_rd_data !== 16'h0 || link_up !== 2'b00 || poll_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got rd=%h link=%b poll=%h, required 0", host_rd_data, link_up, poll_data);
    end
    checks++;
    if (txvr_md_addr !== 5'd0 || txvr_reg_addr !== 5'd0 || txvr_wr_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_txvr: got md=%0d reg=%0d wd=%h, required 0", txvr_md_addr, txvr_reg_addr, txvr_wr_data);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (issues !== 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d issues, required 0", issues);
    end
  endtask

  task automatic test_host_read();
    int busy_cnt = 0, done_cnt = 0, n = 0, i0;
    do_reset();
    busy_len = 10; rsp_tab[7] = 16'h796D; i0 = issues;
    exp_q.push_back(mk(1'b0, 5'd7, 5'd3, 16'h0));
    host_rd = 1'b1; host_md_addr = 5'd7; host_reg_addr = 5'd3; host_wr_data = 16'hAAAA;
    @(negedge clk);
    host_rd = 1'b0;
    while (n < 200) begin
      if (host_busy) busy_cnt++;
      if (host_done) done_cnt++;
      if (!host_busy) break;
      @(negedge clk);
      n++;
    end
    repeat (3) begin
      @(negedge clk);
      if (host_done) done_cnt++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL host_read_timeout: waited %0d cycles, required under 200", n); end
    checks++;
    if (busy_cnt != 14) begin errors++; $display("FAIL host_busy_len: got %0d, required 14", busy_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL host_done_pulses: got %0d, required 1", done_cnt); end
    checks++;
    if (host_rd_data !== 16'h796D) begin errors++; $display("FAIL host_rd_data: got %h, required 796d", host_rd_data); end
    checks++;
    if (issues - i0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL host_read_issues: got %0d issued %0d left, required 1 issued 0 left", issues - i0, exp_q.size());
    end
  endtask

  task automatic test_poll();
    int rounds = 0, ovr = 0, t_first = 0, t_second = 0;
    do_reset();
    busy_len = 10; rsp_tab[0] = 16'h0004; rsp_tab[1] = 16'h0000;
    repeat (2) begin
      exp_q.push_back(mk(1'b0, 5'd0, 5'd1, 16'h0));
      exp_q.push_back(mk(1'b0, 5'd1, 5'd1, 16'h0));
    end
    poll_en = 1'b1;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (poll_overrun) ovr++;
      if (poll_round_done) begin
        rounds++;
        if (rounds == 1) t_first = c; else t_second = c;
      end
    end
    poll_en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rounds != 2) begin errors++; $display("FAIL poll_rounds: got %0d, required 2", rounds); end
    checks++;
    if (t_second - t_first != 100) begin errors++; $display("FAIL poll_period: got %0d, required 100", t_second - t_first); end
    checks++;
    if (link_up !== 2'b01) begin errors++; $display("FAIL poll_link_up: got %b, required 01", link_up); end
    checks++;
    if (poll_data !== 32'h0000_0004) begin errors++; $display("FAIL poll_data: got %h, required 00000004", poll_data); end
    checks++;
    if (ovr != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL poll_sequence: got %0d overruns %0d left, required 0 and 0", ovr, exp_q.size());
    end
  endtask

  task automatic test_alternate();
    logic [15:0] wd [3];
    int n, i0;
    do_reset();
    busy_len = 10; rsp_tab[0] = 16'h0004; rsp_tab[1] = 16'h0004; i0 = issues;
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    exp_q.push_back(mk(1'b1, 5'd5, 5'd16, wd[0]));
    exp_q.push_back(mk(1'b0, 5'd0, 5'd1, 16'h0));
    exp_q.push_back(mk(1'b1, 5'd5, 5'd16, wd[1]));
    exp_q.push_back(mk(1'b0, 5'd1, 5'd1, 16'h0));
    exp_q.push_back(mk(1'b1, 5'd5, 5'd16, wd[2]));
    poll_en = 1'b1;
    repeat (89) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      host_wr = 1'b1; host_md_addr = 5'd5; host_reg_addr = 5'd16; host_wr_data = wd[k];
      @(negedge clk);
      host_wr = 1'b0; host_wr_data = 16'hFFFF;
      n = 0;
      while (host_busy && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n >= 200) begin errors++; $display("FAIL alt_timeout: write %0d waited %0d cycles, required under 200", k, n); end
    end
    repeat (20) @(negedge clk);
    poll_en = 1'b0;
    checks++;
    if (issues - i0 != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL alt_order: got %0d issued %0d left, required 5 issued 0 left", issues - i0, exp_q.size());
    end
    checks++;
    if (txvr_wr_data !== 16'h3333) begin errors++; $display("FAIL alt_wr_hold: got %h, required 3333", txvr_wr_data); end
    checks++;
    if (link_up !== 2'b11) begin errors++; $display("FAIL alt_link_up: got %b, required 11", link_up); end
  endtask

  task automatic test_overrun();
    int ovr = 0, n = 0, i0;
    do_reset();
    busy_len = 110; rsp_tab[0] = 16'h0000; rsp_tab[1] = 16'h0004; i0 = issues;
    exp_q.push_back(mk(1'b0, 5'd0, 5'd1, 16'h0));
    exp_q.push_back(mk(1'b0, 5'd1, 5'd1, 16'h0));
    poll_en = 1'b1;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (poll_overrun) ovr++;
      if (poll_round_done) break;
    end
    poll_en = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (n >= 600) begin errors++; $display("FAIL ovr_timeout: waited %0d cycles, required under 600", n); end
    checks++;
    if (ovr != 2) begin errors++; $display("FAIL ovr_pulses: got %0d, required 2", ovr); end
    checks++;
    if (issues - i0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovr_no_restart: got %0d issued %0d left, required 2 issued 0 left", issues - i0, exp_q.size());
    end
    checks++;
    if (link_up !== 2'b10 || poll_data !== 32'h0004_0000) begin
      errors++;
      $display("FAIL ovr_link_up: got link=%b data=%h, required 10 and 00040000", link_up, poll_data);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, i0;
    do_reset();
    busy_len = 20; rsp_tab[3] = 16'hBEEF; i0 = issues;
    exp_q.push_back(mk(1'b0, 5'd3, 5'd2, 16'h0));
    host_rd = 1'b1; host_md_addr = 5'd3; host_reg_addr = 5'd2;
    @(negedge clk);
    host_rd = 1'b0;
    while (!txvr_busy && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({host_busy, host_done, txvr_reg_rd, txvr_reg_wr} !== 4'b0 || txvr_md_addr !== 5'd0 ||
        txvr_reg_addr !== 5'd0 || host_rd_data !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_clear: got busy=%0b done=%0b md=%0d reg=%0d rd=%h, required all 0",
               host_busy, host_done, txvr_md_addr, txvr_reg_addr, host_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(1'b0, 5'd3, 5'd2, 16'h0));
    host_rd = 1'b1;
    @(negedge clk);
    host_rd = 1'b0;
    n = 0;
    while (!host_done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL rst_mid_timeout: waited %0d cycles, required under 200", n); end
    checks++;
    if (host_rd_data !== 16'hBEEF) begin errors++; $display("FAIL rst_mid_rd_data: got %h, required beef", host_rd_data); end
    checks++;
    if (issues - i0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_issues: got %0d issued %0d left, required 2 issued 0 left", issues - i0, exp_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    int done_cnt = 0, busy_after = 0, n = 0, i0;
    do_reset();
    busy_len = 10; rsp_tab[9] = 16'h1234; i0 = issues;
    exp_q.push_back(mk(1'b0, 5'd9, 5'd4, 16'h0));
    host_rd = 1'b1; host_md_addr = 5'd9; host_reg_addr = 5'd4;
    @(negedge clk);
    host_rd = 1'b0; host_wr = 1'b1; host_md_addr = 5'd2; host_wr_data = 16'hDEAD;
    while (host_busy && n < 200) begin @(negedge clk); n++; end
    if (host_done) done_cnt++;
    host_wr = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (host_done) done_cnt++;
      if (host_busy) busy_after++;
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done: got %0d pulses, required 1", done_cnt); end
    checks++;
    if (busy_after != 0) begin errors++; $display("FAIL ignore_busy: got %0d busy cycles, required 0", busy_after); end
    checks++;
    if (host_rd_data !== 16'h1234) begin errors++; $display("FAIL ignore_rd_data: got %h, required 1234", host_rd_data); end
    checks++;
    if (issues - i0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_issues: got %0d issued %0d left, required 1 issued 0 left", issues - i0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_host_read();
    test_poll();
    test_alternate();
    test_overrun();
    test_reset_mid();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
